fft_frame_loader: RTL and testbench
===================================

# fft_frame_loader

Upstream stage of the 64-point FFT. Accepts complex samples one per cycle over a valid/ready stream and assembles them into ping-pong frame banks. Presents a complete, stable frame on the FFT's parallel `inputRe`/`inputIm` arrays and pulses `start`. It holds that frame until the FFT reports completion, while the other bank fills.

## Interface
- `N`, 64, samples per frame; power of two.
- `W`, 16, sample width per component, two's complement.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  source has a sample on `in_re`/`in_im`.
- `in_ready`  out  1  loader can accept a sample this cycle.
- `in_re`  in  W  real part of the sample.
- `in_im`  in  W  imaginary part of the sample.
- `fft_done`  in  1  one-cycle pulse from the FFT; the active frame is consumed.
- `start`  out  1  one-cycle pulse to the FFT; a new frame is valid.
- `inputRe`  out  W x N  unpacked array `[N-1:0]`, real parts of the active frame.
- `inputIm`  out  W x N  unpacked array `[N-1:0]`, imaginary parts of the active frame.
- `frames_pending`  out  2  number of banks FULL or ACTIVE (0..2).

## Operation
- Two banks, A and B, each holding N x (re, im). Each bank has its own state:
  - EMPTY -> FILLING on the first sample accepted.
  - FILLING -> FULL on sample N-1 accepted.
  - FULL -> ACTIVE when launched.
  - ACTIVE -> EMPTY on `fft_done`.
- Write side:
  - `wr_bank` starts at A.
  - `wr_ptr` is log2(N) bits and starts at 0.
  - A sample is accepted when `in_valid && in_ready`.
  - The sample k of a frame is written to index k (`in_re` -> re[k], `in_im` -> im[k]).
  - On accepting index N-1, the bank goes FULL, `wr_ptr` wraps to 0 and `wr_bank` toggles.
- `in_ready` = !`rst` && (state[`wr_bank`] is EMPTY or FILLING). It is combinational from registered state only, with no dependency on `in_valid`.
- Launch side:
  - When no bank is ACTIVE and some bank is FULL, that bank becomes ACTIVE and `start` pulses.
  - Banks launch in fill order: the oldest FULL bank first.
  - `rd_bank` selects the bank that drives `inputRe`/`inputIm`.
- Outputs always show bank[`rd_bank`]. They are stable for the whole time the bank is ACTIVE, because the write side can never target an ACTIVE or FULL bank.
- `fft_done` while no bank is ACTIVE is ignored.
- `in_valid` while `in_ready` = 0 is ignored. The source must hold its data.
- Input data are stored unmodified; no scaling or saturation.

## Timing
- Reset values:
  - `in_ready`=0 while `rst`=1, and 1 in the first cycle after release.
  - `start`=0, `frames_pending`=0.
  - Both banks EMPTY, `wr_ptr`=0, `wr_bank`=`rd_bank`=A.
  - All bank storage is 0, so `inputRe`/`inputIm` read all zeros.
- Latency: `start` is high in the cycle after the edge that accepts sample N-1, provided no bank is ACTIVE. It is high for exactly one cycle, and `inputRe`/`inputIm` are already valid in that cycle.
- With a bank ACTIVE and the other FULL, `start` pulses in the cycle after the `fft_done` edge, and the outputs switch to the new bank in that same cycle.
- `fft_done` in the same cycle as acceptance of sample N-1 into the other bank:
  - The active bank goes EMPTY and the filled bank goes FULL.
  - The filled bank launches next cycle with one `start`.
  - `in_ready` is 1 in that next cycle (the write side targets the just-freed bank).
- Both banks FULL/ACTIVE: `in_ready`=0 until the cycle after `fft_done`.
- `rst` asserted mid-operation discards all partial and full frames immediately, including any ACTIVE frame. No `start` is issued for them.
- Throughput: one sample per cycle sustained, provided the FFT turns a frame around within N cycles.

## Test plan
- Reset then continuous `in_valid`, samples 0..31 = (4,0) and 32..63 = (0,0):
  - `start` is a single pulse exactly 1 cycle after the 64th accept.
  - `inputRe[0..31]`=4, `inputRe[32..63]`=0, all `inputIm`=0.
  - `frames_pending`=1.
- Same as above, then a second frame of ramp re=k, no `fft_done`:
  - 128 samples are accepted, then `in_ready`=0.
  - The 129th sample is held and not written.
  - Outputs still show frame 1, and `frames_pending`=2.
- Continue with an `fft_done` pulse:
  - `start` pulses in the next cycle, and `inputRe[k]`=k.
  - `in_ready`=1 that cycle, and the held sample is accepted into bank A index 0.
- `fft_done` coincident with the last sample of the other bank: exactly one `start` in the next cycle, and no lost or duplicated sample.
- `rst` after 20 samples of frame 2 while frame 1 is ACTIVE:
  - Outputs go to 0, `start` stays 0, `frames_pending`=0.
  - The next 64 samples form a fresh frame from index 0.
- Spurious `fft_done` with nothing ACTIVE, and `in_valid` toggling every other cycle: no `start` until 64 accepts, and sample order is preserved.

Source files
------------

// File: rtl/fft_frame_loader_if.sv
// fft_frame_loader_if
// Bundles the sample stream, the FFT handshake and the parallel frame
// outputs between the frame loader and its neighbours.
//   master : source / FFT side. Drives in_valid, in_re, in_im and fft_done.
//            Observes in_ready, start, inputRe, inputIm and frames_pending.
//   slave  : the frame loader. Drives the signals the master observes.
interface fft_frame_loader_if #(
  parameter int N = 64,
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_re;
  logic [W-1:0] in_im;
  logic         fft_done;
  logic         start;
  logic [W-1:0] inputRe [N-1:0];
  logic [W-1:0] inputIm [N-1:0];
  logic [1:0]   frames_pending;

  modport master (
    output in_valid, in_re, in_im, fft_done,
    input  in_ready, start, inputRe, inputIm, frames_pending
  );

  modport slave (
    input  in_valid, in_re, in_im, fft_done,
    output in_ready, start, inputRe, inputIm, frames_pending
  );
endinterface

// File: rtl/fft_frame_loader.sv
// fft_frame_loader
// Collects complex samples one per cycle into two ping-pong banks of N
// entries. A completed bank is presented on inputRe/inputIm with a one-cycle
// start pulse and held until the FFT returns fft_done, while the other bank
// fills.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset; discards every frame
//   bus  : slave side of fft_frame_loader_if (stream in, frame out)
module fft_frame_loader #(
  parameter int N = 64,
  parameter int W = 16
) (
  input logic                clk,
  input logic                rst,
  fft_frame_loader_if.slave  bus
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  // Bit 1 is set exactly for the states that hold a complete frame.
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_ACTIVE  = 2'd3;

  logic [1:0]    state_q [0:1];
  logic [1:0]    state_d [0:1];
  logic          wrBank_q, wrBank_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic          rdBank_q, rdBank_d;
  logic          start_q, start_d;
  logic [W-1:0]  re_q [0:1][N-1:0];
  logic [W-1:0]  im_q [0:1][N-1:0];

  logic accept;
  logic anyActive;
  logic launchOk;
  logic launchBank;

  assign bus.in_ready = !rst && (state_q[wrBank_q] == ST_EMPTY ||
                                 state_q[wrBank_q] == ST_FILLING);
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.start = start_q;
  assign bus.frames_pending = {1'b0, state_q[0][1]} + {1'b0, state_q[1][1]};

  // Bank state update. Completion is applied first so a bank freed by
  // fft_done and a bank filled in the same cycle resolve to one launch at
  // this edge; a newly full bank is launched directly when nothing is active.
  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    wrBank_d   = wrBank_q;
    wrPtr_d    = wrPtr_q;
    rdBank_d   = rdBank_q;
    start_d    = 1'b0;
    anyActive  = 1'b0;
    launchOk   = 1'b0;
    launchBank = 1'b0;

    for (int b = 0; b < 2; b++) begin
      if (bus.fft_done && state_q[b] == ST_ACTIVE) begin
        state_d[b] = ST_EMPTY;
      end
    end

    if (accept) begin
      if (wrPtr_q == LAST_IDX) begin
        state_d[wrBank_q] = ST_FULL;
        wrPtr_d  = '0;
        wrBank_d = !wrBank_q;
      end else begin
        state_d[wrBank_q] = ST_FILLING;
        wrPtr_d = wrPtr_q + PW'(1);
      end
    end

    anyActive = (state_d[0] == ST_ACTIVE) || (state_d[1] == ST_ACTIVE);

    // With both banks full the write pointer has wrapped twice, so it points
    // back at the bank that filled first.
    if (!anyActive) begin
      if (state_d[0] == ST_FULL && state_d[1] == ST_FULL) begin
        launchOk   = 1'b1;
        launchBank = wrBank_d;
      end else if (state_d[0] == ST_FULL) begin
        launchOk   = 1'b1;
        launchBank = 1'b0;
      end else if (state_d[1] == ST_FULL) begin
        launchOk   = 1'b1;
        launchBank = 1'b1;
      end
    end

    if (launchOk) begin
      state_d[launchBank] = ST_ACTIVE;
      rdBank_d = launchBank;
      start_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q[0] <= ST_EMPTY;
      state_q[1] <= ST_EMPTY;
      wrBank_q   <= 1'b0;
      wrPtr_q    <= '0;
      rdBank_q   <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      wrBank_q   <= wrBank_d;
      wrPtr_q    <= wrPtr_d;
      rdBank_q   <= rdBank_d;
      start_q    <= start_d;
    end
  end

  // Sample storage. Cleared on reset so the frame outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          re_q[b][k] <= '0;
          im_q[b][k] <= '0;
        end
      end
    end else if (accept) begin
      re_q[wrBank_q][wrPtr_q] <= bus.in_re;
      im_q[wrBank_q][wrPtr_q] <= bus.in_im;
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      bus.inputRe[k] = re_q[rdBank_q][k];
      bus.inputIm[k] = im_q[rdBank_q][k];
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader
// Scoreboard bench for fft_frame_loader. A frame-level model (queues of
// complete frames plus one active frame) predicts in_ready, start,
// frames_pending and the presented frame; each predicted launch is queued
// and popped by an independent monitor whenever the DUT raises start.
module tb_fft_frame_loader;

  localparam int N = 64;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fft_frame_loader_if #(.N(N), .W(W)) bus ();

  fft_frame_loader #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [N*W-1:0] fullReQ[$];
  logic [N*W-1:0] fullImQ[$];
  logic [N*W-1:0] sbReQ[$];
  logic [N*W-1:0] sbImQ[$];
  logic [N*W-1:0] curRe, curIm, actRe, actIm;
  int             curCnt;
  bit             mActive;
  bit             mStart;

  logic [W-1:0] streamRe[$];
  logic [W-1:0] streamIm[$];

  // The loader can take a sample unless two complete frames are held.
  function automatic bit modelReady();
    return (fullReQ.size() + int'(mActive)) < 2;
  endfunction

  function automatic int modelPending();
    return fullReQ.size() + int'(mActive);
  endfunction

  function automatic logic [N*W-1:0] dutRe();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = bus.inputRe[k];
    return v;
  endfunction

  function automatic logic [N*W-1:0] dutIm();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = bus.inputIm[k];
    return v;
  endfunction

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkFrame(string name, logic [N*W-1:0] act, logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < N; k++) begin
        if (act[k*W +: W] !== exp[k*W +: W]) begin
          $display("[TB] FAIL %s: index %0d got %0h expected %0h at %0t",
                   name, k, act[k*W +: W], exp[k*W +: W], $time);
          break;
        end
      end
    end
  endtask

  task automatic modelClear();
    fullReQ.delete();
    fullImQ.delete();
    sbReQ.delete();
    sbImQ.delete();
    curRe   = '0;
    curIm   = '0;
    actRe   = '0;
    actIm   = '0;
    curCnt  = 0;
    mActive = 1'b0;
    mStart  = 1'b0;
  endtask

  // One clock edge of the frame-level model.
  task automatic modelStep(bit acc, logic [W-1:0] re, logic [W-1:0] im, bit done);
    mStart = 1'b0;
    if (done && mActive) mActive = 1'b0;
    if (acc) begin
      curRe[curCnt*W +: W] = re;
      curIm[curCnt*W +: W] = im;
      curCnt++;
      if (curCnt == N) begin
        fullReQ.push_back(curRe);
        fullImQ.push_back(curIm);
        curCnt = 0;
      end
    end
    if (!mActive && fullReQ.size() > 0) begin
      actRe   = fullReQ.pop_front();
      actIm   = fullImQ.pop_front();
      mActive = 1'b1;
      mStart  = 1'b1;
      sbReQ.push_back(actRe);
      sbImQ.push_back(actIm);
    end
  endtask

  task automatic checkOutput();
    checkVal("start", 32'(bus.start), 32'(mStart));
    checkVal("frames_pending", 32'(bus.frames_pending), 32'(modelPending()));
    if (mActive) begin
      checkFrame("activeRe", dutRe(), actRe);
      checkFrame("activeIm", dutIm(), actIm);
    end
  endtask

  // Drives one cycle of stimulus from just after a falling edge.
  task automatic applyStimulus(input bit v, input logic [W-1:0] re,
                               input logic [W-1:0] im, input bit d,
                               output bit acc);
    bit expReady;
    bus.in_valid = v;
    bus.in_re    = re;
    bus.in_im    = im;
    bus.fft_done = d;
    expReady = modelReady();
    checkVal("in_ready", 32'(bus.in_ready), 32'(expReady));
    acc = v && expReady;
    @(posedge clk);
    modelStep(acc, re, im, d);
    @(negedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_re    = '0;
    bus.in_im    = '0;
    bus.fft_done = 1'b0;
    modelClear();
    streamRe.delete();
    streamIm.delete();
    #1;
    checkVal("reset in_ready", 32'(bus.in_ready), 32'd0);
    checkVal("reset start", 32'(bus.start), 32'd0);
    checkVal("reset frames_pending", 32'(bus.frames_pending), 32'd0);
    checkFrame("reset inputRe", dutRe(), '0);
    checkFrame("reset inputIm", dutIm(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("post-reset in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // kind 0: (4,0) then (0,0) halves; 1: ramp re=k; 2: random.
  task automatic pushFrame(int kind);
    for (int k = 0; k < N; k++) begin
      case (kind)
        0: begin
          streamRe.push_back((k < N/2) ? W'(4) : W'(0));
          streamIm.push_back(W'(0));
        end
        1: begin
          streamRe.push_back(W'(k));
          streamIm.push_back(W'($urandom));
        end
        default: begin
          streamRe.push_back(W'($urandom));
          streamIm.push_back(W'($urandom));
        end
      endcase
    end
  endtask

  // vmode 0: valid whenever data; 1: every other cycle; 2: random.
  // dmode 0: no done; 1: done in first cycle; 2: done with the last
  // sample of a frame; 3: random done.
  task automatic runCycles(int n, int vmode, int dmode);
    for (int c = 0; c < n; c++) begin
      bit have, v, d, acc;
      logic [W-1:0] re, im;
      have = streamRe.size() > 0;
      case (vmode)
        0:       v = have;
        1:       v = have && (c % 2 == 0);
        default: v = have && ($urandom_range(0, 3) != 0);
      endcase
      re = have ? streamRe[0] : '0;
      im = have ? streamIm[0] : '0;
      case (dmode)
        0:       d = 1'b0;
        1:       d = (c == 0);
        2:       d = mActive && (curCnt == N-1) && v && modelReady();
        default: d = ($urandom_range(0, 7) == 0);
      endcase
      applyStimulus(v, re, im, d, acc);
      if (acc) begin
        void'(streamRe.pop_front());
        void'(streamIm.pop_front());
      end
    end
  endtask

  // Monitor: every start pulse consumes one predicted frame.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bus.start === 1'b1) begin
        if (sbReQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected start: got 1 expected 0 at %0t", $time);
        end else begin
          checkFrame("launchRe", dutRe(), sbReQ.pop_front());
          checkFrame("launchIm", dutIm(), sbImQ.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();

    // First frame, then a ramp frame and a random frame with no completion.
    pushFrame(0);
    runCycles(64, 0, 0);
    pushFrame(1);
    pushFrame(2);
    runCycles(75, 0, 0);

    // Completion releases the held sample into the freed bank.
    runCycles(1, 0, 1);
    pushFrame(2);
    runCycles(140, 0, 2);
    runCycles(10, 0, 0);

    // Reset while a frame is active and the next one is partly filled.
    doReset();
    pushFrame(2);
    pushFrame(2);
    runCycles(84, 0, 0);
    doReset();
    pushFrame(2);
    runCycles(66, 0, 0);

    // Spurious completions and a gappy source.
    doReset();
    pushFrame(2);
    pushFrame(2);
    runCycles(200, 1, 3);

    // Random traffic.
    for (int f = 0; f < 6; f++) pushFrame(2);
    runCycles(800, 2, 3);

    @(negedge clk);
    checkVal("unobserved launches", 32'(sbReQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
